uart_tx_port: RTL and testbench

Memory-mapped UART transmitter peripheral. It is the responder on one slot of the Hack I/O map. Its write strobe is driven from one of the IO decoder's per-slot load lines (e.g. load0010), and its status word feeds the matching per-slot read-data input (e.g. in0010). CPU writes push bytes into a small FIFO, which the block serialises as 8N1 frames on the tx pin.

---
 rtl/hack_io_pkg.sv | 23 ++
 rtl/io_sync_fifo.sv | 70 +++++++
 rtl/uart_tx_port.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_port.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_io_pkg.sv
// Shared definitions for Hack I/O map peripherals: status/control bit positions,
// UART defaults and the transmitter state encoding.
package hack_io_pkg;

  // Status word bit positions
  localparam int unsigned STAT_FULL = 15;
  localparam int unsigned STAT_BUSY = 14;
  localparam int unsigned STAT_OVF  = 13;

  // Control word: writing with this bit set clears the sticky overflow flag
  localparam int unsigned CTRL_CLR_OVF = 15;

  // 25 MHz system clock / 115200 baud
  localparam int unsigned UART_BAUD_DIV = 217;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_tx_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with occupancy count. The head entry is presented combinationally
// on rd_data. A push while full is accepted only when a pop happens on the same edge.
module io_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Qualify requests; a pop frees the slot a simultaneous push writes into
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  // Pointer and occupancy next state; pointers wrap naturally (DEPTH is a power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter. CPU writes queue bytes in a FIFO which are sent as
// 8N1 frames on tx, back to back with no idle gap. The status word reports full, busy,
// sticky overflow and FIFO occupancy.
module uart_tx_port
  import hack_io_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = UART_BAUD_DIV,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        tx
);

  localparam int unsigned     BAUD_W    = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  uart_tx_state_t     state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               ovf_q, ovf_d;

  logic               fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [7:0]         fifo_rd;
  logic               wr_clr, wr_byte, baud_end;

  io_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (in[7:0]),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Write decode: control writes clear overflow; data writes push or overflow.
  // Full is judged after a same-edge pop, so a push alongside a pop is never dropped.
  always_comb begin
    wr_clr    = load & in[CTRL_CLR_OVF];
    wr_byte   = load & ~in[CTRL_CLR_OVF];
    fifo_push = wr_byte & (~fifo_full | fifo_pop);
    ovf_d     = ovf_q;
    if (wr_clr) begin
      ovf_d = 1'b0;
    end else if (wr_byte && !fifo_push) begin
      ovf_d = 1'b1;
    end
  end

  // Frame sequencer next state: baud counter, bit index, shifter and FIFO pop
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    baud_end = (baud_q == BAUD_LAST);
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is queued
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd;
            bit_d    = '0;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer and overflow registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

  // Line driver, decoded from registers only so reset forces the idle level at once
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      StStart: tx = 1'b0;
      StData:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  // Status word, built purely from registered state
  always_comb begin
    out              = '0;
    out[STAT_FULL]   = fifo_full;
    out[STAT_BUSY]   = (state_q != StIdle) | ~fifo_empty;
    out[STAT_OVF]    = ovf_q;
    out[CNT_W-1:0]   = fifo_count;
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port (BAUD_DIV=4, FIFO_DEPTH=4). Stimulus queues expected frames
// (byte plus start edge); a line monitor decodes tx cycle by cycle and checks them.
module tb_uart_tx_port;

  localparam int unsigned BD = 4;
  localparam int unsigned FD = 4;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] din;
  logic [15:0] dout;
  logic        tx;

  int unsigned cyc;
  int          tests;
  int          fails;

  typedef struct {
    logic [7:0]  data;
    int unsigned start;
  } exp_t;

  exp_t sb[$];

  uart_tx_port #(
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .in    (din),
    .out   (dout),
    .tx    (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h, want 0x%04h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_frame(input logic [7:0] data, input int unsigned start);
    exp_t e;
    e.data  = data;
    e.start = start;
    sb.push_back(e);
  endtask

  // Present a write sampled at the next rising edge; returns that edge's index
  task automatic write(input logic [15:0] d, output int unsigned wedge);
    @(negedge clk);
    load = 1'b1;
    din  = d;
    @(posedge clk);
    wedge = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    load = 1'b0;
    din  = '0;
  endtask

  // Bounded wait for the port to go quiet, then confirm every expected frame was seen
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (dout !== 16'h0000 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check16({name, "_drain_out"}, dout, 16'h0000);
    repeat (5) @(negedge clk);
    check_int({name, "_frames_left"}, sb.size(), 0);
  endtask

  // Line monitor: on a start bit, pop the expected frame and check all 10*BD cycles
  initial begin
    exp_t        e;
    logic [9:0]  frame;
    int unsigned st;
    int          bad;
    logic        bad_val;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        st = cyc - 1;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: start at edge %0d, want no frame", st);
          repeat (10 * BD - 1) @(negedge clk);
        end else begin
          e = sb.pop_front();
          check_int("frame_start_edge", int'(st), int'(e.start));
          frame   = {1'b1, e.data, 1'b0};
          bad     = -1;
          bad_val = 1'b0;
          aborted = 1'b0;
          for (int i = 0; i < 10 * int'(BD); i++) begin
            if (i > 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (tx !== frame[i / BD] && bad < 0) begin
              bad     = i;
              bad_val = tx;
            end
          end
          if (!aborted) begin
            tests++;
            if (bad >= 0) begin
              fails++;
              $display("FAIL frame_bits 0x%02h: cycle %0d of frame got tx=%b, want %b",
                       e.data, bad, bad_val, frame[bad / BD]);
            end
          end
        end
      end
    end
  end

  initial begin
    int unsigned w;
    int unsigned w0;
    int          bad;
    logic [7:0]  s3 [6];

    tests = 0;
    fails = 0;

    // 1. Reset held with a write pending: nothing may happen
    rst_n = 1'b0;
    load  = 1'b1;
    din   = 16'h0041;
    bad   = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx !== 1'b1 || dout !== 16'h0000) bad++;
    end
    check_int("reset_hold_bad_cycles", bad, 0);
    check16("reset_out", dout, 16'h0000);
    load  = 1'b0;
    din   = '0;
    rst_n = 1'b1;
    bad   = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check_int("post_reset_tx_idle", bad, 0);
    check16("post_reset_out", dout, 16'h0000);

    // 2. Single byte: timing and status through the frame
    write(16'h0055, w);
    expect_frame(8'h55, w + 1);
    idle();
    check16("s2_out_queued", dout, 16'h4001);
    @(negedge clk);
    check16("s2_out_popped", dout, 16'h4000);
    repeat (39) @(negedge clk);
    check16("s2_out_stop_bit", dout, 16'h4000);
    @(negedge clk);
    check16("s2_out_done", dout, 16'h0000);
    wait_drain("s2");

    // 3. Six back-to-back writes: first popped immediately, sixth overflows
    s3[0] = 8'hA5; s3[1] = 8'h3C; s3[2] = 8'h01;
    s3[3] = 8'h80; s3[4] = 8'hFF; s3[5] = 8'h77;
    w0 = 0;
    for (int i = 0; i < 6; i++) begin
      write({8'h00, s3[i]}, w);
      if (i == 0) w0 = w;
      if (i < 5) expect_frame(s3[i], w0 + 1 + 40 * i);
    end
    idle();
    check16("s3_full_busy_ovf", dout, 16'hE004);

    // 4. Clear overflow: flag drops, nothing pushed
    write(16'h8000, w);
    idle();
    check16("s4_ovf_cleared", dout, 16'hC004);
    wait_drain("s3");

    // 6. Upper data bits are ignored
    write(16'h7F41, w);
    expect_frame(8'h41, w + 1);
    idle();
    check16("s6_out_queued", dout, 16'h4001);
    wait_drain("s6");

    // 5. Asynchronous reset mid-frame with a second byte still queued
    write(16'h00AA, w);
    expect_frame(8'hAA, w + 1);
    write(16'h0066, w0);
    idle();
    check16("s5_out_one_queued", dout, 16'h4001);
    repeat (14) @(negedge clk);
    check16("s5_pre_reset_tx", {15'd0, tx}, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    check16("s5_async_tx", {15'd0, tx}, 16'h0001);
    check16("s5_async_out", dout, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad   = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check_int("s5_post_reset_tx_idle", bad, 0);
    check16("s5_post_reset_out", dout, 16'h0000);
    check_int("s5_frames_left", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
